sync_receiver: RTL and testbench
================================

SYNC_RECEIVER -- requirements
Module: sync_receiver

Interface
REQ-001 Parameter DATA_W, default 8: payload word width in bits, range 2..32.
REQ-002 Parameter SYNC_W, default 8: sync pattern length in bits, range 4..32.
REQ-003 Parameter SYNC_WORD, default 8'hD5: sync pattern, MSB received first.
REQ-004 Parameter SYNC_TOL, default 0: maximum bit mismatches accepted as a sync hit.
REQ-005 Parameter FRAME_WORDS, default 4: payload words per frame, range 1..255.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_i  input  1  demodulated serial bit.
REQ-009 bit_valid_i  input  1  data_i is a new bit this cycle.
REQ-010 m_data_o  output  DATA_W  received payload word, MSB first on the line.
REQ-011 m_valid_o  output  1  m_data_o holds a word.
REQ-012 m_ready_i  input  1  consumer accepts the word; transfer when valid and ready are both high.
REQ-013 m_last_o  output  1  word is the last of its frame.
REQ-014 m_err_o  output  1  word failed its parity check.
REQ-015 locked_o  output  1  FSM is in PAYLOAD.
REQ-016 ovf_o  output  1  sticky flag: a completed word was dropped.

Function
REQ-017 FSM states HUNT and PAYLOAD; only bit_valid_i cycles advance shift register, bit and word counters.
REQ-018 HUNT: each valid bit shifts into a SYNC_W history register; hit = popcount(history XOR SYNC_WORD) <= SYNC_TOL, evaluated including the current bit.
REQ-019 On a hit: go to PAYLOAD; the next valid bit is payload bit DATA_W-1 of word 0.
REQ-020 PAYLOAD: DATA_W valid bits form one word, MSB first; the word completes on its final bit (final parity bit when RX_PARITY_EN is defined).
REQ-021 m_valid_o rises on the cycle after word completion; latency is 1 clk.
REQ-022 m_data_o, m_last_o and m_err_o are stable while m_valid_o=1 and m_ready_i=0.
REQ-023 Completion with m_valid_o=1, m_ready_i=0: the new word is dropped, ovf_o sets, and the word count still advances.
REQ-024 Completion with m_valid_o=1, m_ready_i=1 in the same cycle: the new word loads with no overflow.
REQ-025 Completion of word FRAME_WORDS-1 sets m_last_o with that word, returns the FSM to HUNT and clears the history register to all zeros.
REQ-026 A new sync search needs SYNC_W fresh valid bits after a frame ends; sync is not checked during PAYLOAD.
REQ-027 ovf_o clears only on reset.

Reset
REQ-028 While reset=1: FSM=HUNT; history, bit and word counters=0; m_data_o=0; m_valid_o=0; m_last_o=0; m_err_o=0; locked_o=0; ovf_o=0.
REQ-029 Reset mid-frame discards any partial word and any pending output word; data_i and bit_valid_i are ignored during reset.

Configuration
REQ-030 Macro RX_PARITY_EN defined: each word is followed by one even-parity bit; m_err_o=1 when the XOR of the word and its parity bit is 1; the word is still delivered.
REQ-031 Macro RX_PARITY_EN undefined: no parity bit is received; m_err_o is constant 0.

Structure
REQ-032 Package rx_pkg holds: the state enum (HUNT, PAYLOAD), parameter default constants, and a popcount function.
REQ-033 Sub-module sync_correlator holds the history register and Hamming-distance comparison; it outputs a one-cycle hit pulse.

Verification
REQ-034 Defaults; bits D5 then A5,3C,0F,F0 all valid each cycle -> four words A5,3C,0F,F0; m_last_o only on F0; locked_o low after the final bit.
REQ-035 SYNC_TOL=1; sync D4 (1 error) then 4 words -> frame received; SYNC_TOL=0 same stimulus -> no m_valid_o.
REQ-036 m_ready_i held low through a frame -> first word A5 stays held; ovf_o=1 after the second word completes; release -> only A5 transfers.
REQ-037 bit_valid_i toggling 1/0 every cycle -> identical words to REQ-034; each m_valid_o one clk after the completing bit.
REQ-038 Reset asserted after 3 payload bits, then a full frame -> all outputs 0 during reset; only the new frame's words appear.
REQ-039 RX_PARITY_EN defined; word 3C with parity bit 1 -> m_err_o=1, m_data_o=3C; with parity bit 0 -> m_err_o=0.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg: shared state type, parameter defaults and popcount helper.
// Used by sync_receiver and sync_correlator.
package rx_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_t;

  localparam int          DEF_DATA_W      = 8;
  localparam int          DEF_SYNC_W      = 8;
  localparam logic [31:0] DEF_SYNC_WORD   = 32'h0000_00D5;
  localparam int          DEF_SYNC_TOL    = 0;
  localparam int          DEF_FRAME_WORDS = 4;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// sync_correlator: sync history shifter and Hamming-distance match.
// o_hit pulses on the valid bit that completes a match.
module sync_correlator
  import rx_pkg::*;
#(
  parameter int              SYNC_W    = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD),
  parameter int              SYNC_TOL  = DEF_SYNC_TOL
) (
  input  logic clk,
  input  logic reset,
  input  logic i_shift,
  input  logic i_bit,
  input  logic i_clear,
  output logic o_hit
);

  logic [SYNC_W-1:0] r_hist;
  logic [SYNC_W-1:0] w_next;
  logic [31:0]       w_diff;

  assign w_next = {r_hist[SYNC_W-2:0], i_bit};
  assign w_diff = 32'(w_next ^ SYNC_WORD);
  assign o_hit  = i_shift && (popcount(w_diff) <= 6'(SYNC_TOL));

  // History shifts on hunted bits; wiped when a frame ends.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_hist <= '0;
    end else if (i_shift) begin
      r_hist <= w_next;
    end
  end

endmodule

// File: rtl/sync_receiver.sv
// sync_receiver: sync hunt, framed word capture, valid/ready output.
// Define RX_PARITY_EN to receive an even-parity bit after each word.
module sync_receiver
  import rx_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(DEF_SYNC_WORD),
  parameter int                SYNC_TOL    = DEF_SYNC_TOL,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_i,
  input  logic              bit_valid_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              m_err_o,
  output logic              locked_o,
  output logic              ovf_o
);

`ifdef RX_PARITY_EN
  localparam int WORD_BITS = DATA_W + 1;
`else
  localparam int WORD_BITS = DATA_W;
`endif
  localparam int SH_W = WORD_BITS - 1;
  localparam int BC_W = $clog2(WORD_BITS);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [BC_W-1:0]   r_bit_cnt;
  logic [7:0]        r_word_cnt;
  logic [SH_W-1:0]   r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_err;
  logic              r_ovf;

  logic              w_hunt_bit;
  logic              w_pay_bit;
  logic              w_hit;
  logic              w_bit_end;
  logic              w_done;
  logic              w_last;
  logic              w_load;
  logic [DATA_W-1:0] w_word;
  logic              w_err;

  assign w_hunt_bit = bit_valid_i && (r_state == HUNT);
  assign w_pay_bit  = bit_valid_i && (r_state == PAYLOAD);
  assign w_bit_end  = r_bit_cnt == BC_W'(WORD_BITS - 1);
  assign w_done     = w_pay_bit && w_bit_end;
  assign w_last     = r_word_cnt == 8'(FRAME_WORDS - 1);
  assign w_load     = w_done && (!r_valid || m_ready_i);

`ifdef RX_PARITY_EN
  assign w_word = r_shift;
  assign w_err  = ^{r_shift, data_i};
`else
  assign w_word = {r_shift, data_i};
  assign w_err  = 1'b0;
`endif

  sync_correlator #(
    .SYNC_W   (SYNC_W),
    .SYNC_WORD(SYNC_WORD),
    .SYNC_TOL (SYNC_TOL)
  ) u_corr (
    .clk    (clk),
    .reset  (reset),
    .i_shift(w_hunt_bit),
    .i_bit  (data_i),
    .i_clear(w_done && w_last),
    .o_hit  (w_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock on a sync hit; drop back to hunting after the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT:    if (w_hit) w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_done && w_last) w_state_nxt = HUNT;
    endcase
  end

  // Payload bit/word counting and word assembly, MSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
    end else if (w_pay_bit) begin
      if (!w_bit_end) begin
        r_shift <= SH_W'({r_shift, data_i});
      end
      if (w_bit_end) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= w_last ? 8'd0 : r_word_cnt + 8'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
    end
  end

  // Output holding register; a word arriving while blocked is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
        r_last  <= w_last;
        r_err   <= w_err;
      end else if (m_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_done && r_valid && !m_ready_i) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign m_data_o  = r_data;
  assign m_valid_o = r_valid;
  assign m_last_o  = r_last;
  assign m_err_o   = r_err;
  assign locked_o  = r_state == PAYLOAD;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_sync_receiver.sv
// tb_sync_receiver: directed and random frames against a bit-stream model.
// Two receivers run side by side: sync tolerance 0 and tolerance 1.
module tb_sync_receiver;

  localparam int DW = 8;
  localparam int SW = 8;
  localparam int FW = 4;
  localparam logic [SW-1:0] SYNC = 8'hD5;
`ifdef RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = DW + (PAR ? 1 : 0);

  logic clk;
  logic reset;
  logic data;
  logic bv;
  logic m_ready;

  logic [DW-1:0] dat [2];
  logic          vld [2];
  logic          lst [2];
  logic          err [2];
  logic          lck [2];
  logic          ovf [2];

  int checks;
  int failures;
  bit chk_en;
  bit rnd_rdy;

  sync_receiver #(.SYNC_TOL(0)) dut (
    .clk(clk), .reset(reset), .data_i(data), .bit_valid_i(bv),
    .m_data_o(dat[0]), .m_valid_o(vld[0]), .m_ready_i(m_ready),
    .m_last_o(lst[0]), .m_err_o(err[0]), .locked_o(lck[0]),
    .ovf_o(ovf[0])
  );

  sync_receiver #(.SYNC_TOL(1)) dut_t1 (
    .clk(clk), .reset(reset), .data_i(data), .bit_valid_i(bv),
    .m_data_o(dat[1]), .m_valid_o(vld[1]), .m_ready_i(m_ready),
    .m_last_o(lst[1]), .m_err_o(err[1]), .locked_o(lck[1]),
    .ovf_o(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            lock;
    logic [SW-1:0] hist;
    logic [DW:0]   acc;
    int            nb;
    int            nw;
    bit            full;
    logic [DW-1:0] d;
    bit            last;
    bit            err;
    bit            ovf;
  } mdl_t;

  mdl_t md [2];
  bit            m_done;
  logic [DW-1:0] m_word;
  bit            m_last;
  bit            m_err;

  logic [DW+1:0] obs0 [$];
  logic [DW+1:0] obs1 [$];
  logic [DW+1:0] eq [$];

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [DW+1:0] ent(bit l, bit e, logic [DW-1:0] d);
    return {l, e, d};
  endfunction

  // Reference: bit-stream view of sync search, framing and hand-off.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        md[k].lock = 0; md[k].hist = '0; md[k].acc = '0;
        md[k].nb = 0;   md[k].nw = 0;    md[k].full = 0;
        md[k].d = '0;   md[k].last = 0;  md[k].err = 0;
        md[k].ovf = 0;
      end else begin
        m_done = 0;
        if (bv) begin
          if (!md[k].lock) begin
            md[k].hist = {md[k].hist[SW-2:0], data};
            // instance k tolerates k mismatched sync bits
            if ($countones(md[k].hist ^ SYNC) <= k) md[k].lock = 1;
          end else begin
            md[k].acc = {md[k].acc[DW-1:0], data};
            md[k].nb++;
            if (md[k].nb == NB) begin
              m_done = 1;
              m_word = PAR ? md[k].acc[DW:1] : md[k].acc[DW-1:0];
              m_err  = PAR ? ^md[k].acc : 1'b0;
              md[k].nw++;
              m_last = (md[k].nw == FW);
              if (m_last) begin
                md[k].lock = 0; md[k].nw = 0; md[k].hist = '0;
              end
              md[k].nb = 0; md[k].acc = '0;
            end
          end
        end
        if (m_done && md[k].full && !m_ready) md[k].ovf = 1;
        else if (m_done) begin
          md[k].full = 1; md[k].d = m_word;
          md[k].last = m_last; md[k].err = m_err;
        end else if (md[k].full && m_ready) md[k].full = 0;
      end
    end
  end

  // Cycle checks against the model, and transfer capture.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid[%0d]", k), vld[k], md[k].full);
        chk($sformatf("locked[%0d]", k), lck[k], md[k].lock);
        chk($sformatf("ovf[%0d]", k), ovf[k], md[k].ovf);
        if (md[k].full) begin
          chk($sformatf("data[%0d]", k), dat[k], md[k].d);
          chk($sformatf("last[%0d]", k), lst[k], md[k].last);
          chk($sformatf("err[%0d]", k), err[k], md[k].err);
        end
      end
      if (vld[0] && m_ready) obs0.push_back({lst[0], err[0], dat[0]});
      if (vld[1] && m_ready) obs1.push_back({lst[1], err[1], dat[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bv = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(logic b, int gap);
    if (rnd_rdy) m_ready = ($urandom_range(0, 3) != 0);
    data = b;
    bv = 1'b1;
    tick();
    bv = 1'b0;
    repeat (gap) begin
      data = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_sync(logic [SW-1:0] s, int gap);
    for (int i = SW - 1; i >= 0; i--) send_bit(s[i], gap);
  endtask

  task automatic send_word(logic [DW-1:0] w, bit perr, int gap);
    for (int i = DW - 1; i >= 0; i--) send_bit(w[i], gap);
    if (PAR) send_bit(^w ^ perr, gap);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    bv = 1'b0;
    repeat (n) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_data[%0d]", k), dat[k], '0);
      chk($sformatf("rst_valid[%0d]", k), vld[k], 1'b0);
      chk($sformatf("rst_last[%0d]", k), lst[k], 1'b0);
      chk($sformatf("rst_err[%0d]", k), err[k], 1'b0);
      chk($sformatf("rst_lock[%0d]", k), lck[k], 1'b0);
      chk($sformatf("rst_ovf[%0d]", k), ovf[k], 1'b0);
    end
    tick();
    reset = 1'b0;
    obs0.delete();
    obs1.delete();
  endtask

  task automatic cmp_obs(string tag, int k);
    logic [DW+1:0] q [$];
    if (k == 0) q = obs0;
    else q = obs1;
    chk({tag, "_count"}, q.size(), eq.size());
    for (int i = 0; i < eq.size() && i < q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), q[i], eq[i]);
  endtask

  task automatic std_eq();
    eq.delete();
    eq.push_back(ent(0, 0, 8'hA5));
    eq.push_back(ent(0, 0, 8'h3C));
    eq.push_back(ent(0, 0, 8'h0F));
    eq.push_back(ent(1, 0, 8'hF0));
  endtask

  initial begin
    logic [SW-1:0] s;
    checks = 0; failures = 0;
    reset = 1'b1; bv = 1'b0; data = 1'b0;
    m_ready = 1'b1; chk_en = 1'b0; rnd_rdy = 1'b0;
    tick();
    chk_en = 1'b1;
    do_reset(3);

    // Basic frame, back-to-back bits.
    send_sync(SYNC, 0);
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    send_word(8'h0F, 0, 0);
    send_word(8'hF0, 0, 0);
    chk("end_locked", lck[0], 1'b0);
    chk("end_valid", vld[0], 1'b1);
    chk("end_data", dat[0], 8'hF0);
    chk("end_last", lst[0], 1'b1);
    idle(4);
    std_eq();
    cmp_obs("frame", 0);
    cmp_obs("frame_t1", 1);

    // One-bit sync error: only the tolerant receiver locks.
    do_reset(2);
    send_sync(8'hD4, 0);
    send_word(8'hA5, 0, 0);
    send_word(8'h3C, 0, 0);
    send_word(8'h0F, 0, 0);
    send_word(8'hF0, 0, 0);
    idle(4);
    cmp_obs("tol_t1", 1);
    eq.delete();
    cmp_obs("tol_t0", 0);

    // Consumer stalled for the whole frame.
    do_reset(2);
    m_ready = 1'b0;
    send_sync(SYNC, 0);
    send_word(8'hA5, 0, 0);
    chk("hold_valid", vld[0], 1'b1);
    chk("hold_data", dat[0], 8'hA5);
    chk("hold_ovf0", ovf[0], 1'b0);
    send_word(8'h3C, 0, 0);
    chk("ovf_set", ovf[0], 1'b1);
    chk("hold_data2", dat[0], 8'hA5);
    send_word(8'h0F, 0, 0);
    send_word(8'hF0, 0, 0);
    chk("hold_last", lst[0], 1'b0);
    idle(3);
    m_ready = 1'b1;
    idle(4);
    chk("ovf_sticky", ovf[0], 1'b1);
    eq.delete();
    eq.push_back(ent(0, 0, 8'hA5));
    cmp_obs("stall", 0);

    // Bits valid every other cycle.
    do_reset(2);
    send_sync(SYNC, 1);
    send_word(8'hA5, 0, 1);
    send_word(8'h3C, 0, 1);
    send_word(8'h0F, 0, 1);
    send_word(8'hF0, 0, 1);
    idle(4);
    std_eq();
    cmp_obs("gap", 0);

    // Reset part-way through a word, then a fresh frame.
    do_reset(2);
    send_sync(SYNC, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    do_reset(2);
    send_sync(SYNC, 0);
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 0);
    send_word(8'h33, 0, 0);
    send_word(8'h44, 0, 0);
    idle(4);
    eq.delete();
    eq.push_back(ent(0, 0, 8'h11));
    eq.push_back(ent(0, 0, 8'h22));
    eq.push_back(ent(0, 0, 8'h33));
    eq.push_back(ent(1, 0, 8'h44));
    cmp_obs("midrst", 0);

`ifdef RX_PARITY_EN
    // Parity flag follows the received parity bit.
    do_reset(2);
    send_sync(SYNC, 0);
    send_word(8'h3C, 1, 0);
    send_word(8'h3C, 0, 0);
    send_word(8'h5A, 1, 0);
    send_word(8'h81, 0, 0);
    idle(4);
    eq.delete();
    eq.push_back(ent(0, 1, 8'h3C));
    eq.push_back(ent(0, 0, 8'h3C));
    eq.push_back(ent(0, 1, 8'h5A));
    eq.push_back(ent(1, 0, 8'h81));
    cmp_obs("parity", 0);
`endif

    // Random frames, gaps, noise, near-miss syncs and back-pressure.
    do_reset(2);
    rnd_rdy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      repeat ($urandom_range(0, 6)) send_bit(1'($urandom), 0);
      s = SYNC;
      if ($urandom_range(0, 2) == 0) s[$urandom_range(0, SW - 1)] ^= 1'b1;
      send_sync(s, $urandom_range(0, 1));
      for (int w = 0; w < FW; w++)
        send_word(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    rnd_rdy = 1'b0;
    m_ready = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
